// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative multiply/divide unit.
// Holds the op encoding, FSM state type and default width.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  localparam int MD_WIDTH = 32;
  localparam int ITER     = MD_WIDTH;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done handshake between controller and unit.
// master drives start/op/a/b; slave returns busy/done/hi/lo.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU producing {hi,lo}.
// Ports: clk, reset (async, active-low), bus (muldiv_if.slave).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opb_q;
  logic               div_q;
  logic               sgn_q;
  logic               sa_q;
  logic               sb_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_n;
  logic               neg_p;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign is_sgn = ~bus.op[0];

  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (is_sgn && bus.a[WIDTH-1]) a_mag = -bus.a;
    if (is_sgn && bus.b[WIDTH-1]) b_mag = -bus.b;
  end

  // acc holds {upper, lower}: product halves for MUL,
  // {remainder, dividend/quotient} for DIV.
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
          + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    shl   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    // remainder < divisor keeps diff within a signed W+1 range
    diff  = shl - {1'b0, opb_q};
    rem_n = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
    acc_d = {sum, acc_q[WIDTH-1:1]};
    if (div_q)
      acc_d = {rem_n, acc_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    neg_p = sgn_q & (sa_q ^ sb_q);
    quo   = acc_q[WIDTH-1:0];
    rem   = acc_q[2*WIDTH-1:WIDTH];
    {fix_hi, fix_lo} = neg_p ? -acc_q : acc_q;
    if (div_q) begin
      fix_lo = neg_p ? -quo : quo;
      if (dz_q) fix_lo = {WIDTH{1'b1}};
      // remainder follows the dividend's sign
      fix_hi = (sgn_q & sa_q) ? -rem : rem;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= bus.op[1] ? DIV : MUL;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            acc_q   <= {{WIDTH{1'b0}},
                        (bus.op[1] ? a_mag : b_mag)};
            opb_q   <= bus.op[1] ? b_mag : a_mag;
            div_q   <= bus.op[1];
            sgn_q   <= is_sgn;
            sa_q    <= bus.a[WIDTH-1];
            sb_q    <= bus.b[WIDTH-1];
            dz_q    <= bus.op[1] & (bus.b == '0);
          end
        end
        MUL, DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
